float_normalizer: RTL

FLOAT_NORMALIZER -- requirements
Module: float_normalizer

---
 rtl/float_normalizer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/float_normalizer.sv
// Post-add normalizer for IEEE-754 single precision: shifts, rounds and packs a raw sum.
// Optional `ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the result is truncated.
module float_normalizer #(
  parameter int LZ_MAX = 26
) (
  input  logic        clk,
  input  logic        res,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [27:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_float,
  output logic        of,
  output logic        uf
);

  localparam int CW = $clog2(LZ_MAX + 1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t        state_q, state_d;
  logic          sign_q, sign_d;
  logic [8:0]    exp_q, exp_d;
  logic [27:0]   mant_q, mant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          special_q, special_d;
  logic [31:0]   float_q, float_d;
  logic          of_q, of_d;
  logic          uf_q, uf_d;

  logic          round_inc;
  logic [24:0]   mant_rnd;
  logic [22:0]   frac_rnd;
  logic [8:0]    exp_rnd;

  // Rounding looks at the 24-bit significand mant[26:3] plus guard/round/sticky.
`ifdef ROUND_NEAREST_EN
  assign round_inc = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
`else
  assign round_inc = 1'b0;
`endif

  assign mant_rnd = {1'b0, mant_q[26:3]} + {24'd0, round_inc};
  assign frac_rnd = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];
  assign exp_rnd  = mant_rnd[24] ? exp_q + 9'd1 : exp_q;

  // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    mant_d    = mant_q;
    cnt_d     = cnt_q;
    special_d = special_q;
    float_d   = float_q;
    of_d      = of_q;
    uf_d      = uf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d    = in_sign;
          exp_d     = {1'b0, in_exp};
          mant_d    = in_mant;
          cnt_d     = '0;
          special_d = (in_exp == 8'hFF);
          of_d      = 1'b0;
          uf_d      = 1'b0;
          state_d   = NORM;
        end
      end

      NORM: begin
        if (special_q) begin
          float_d = {sign_q, 8'hFF, mant_q[25:3]};
          of_d    = 1'b0;
          state_d = DONE;
        end else if (mant_q == '0) begin
          float_d = {sign_q, 31'd0};
          uf_d    = 1'b0;
          state_d = DONE;
        end else if (exp_q == 9'd0) begin
          // Denormal inputs are not supported: flush before any shifting.
          float_d = {sign_q, 31'd0};
          uf_d    = 1'b1;
          state_d = DONE;
        end else if (mant_q[27]) begin
          mant_d = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
          exp_d  = exp_q + 9'd1;
        end else if (mant_q[26]) begin
          state_d = ROUND;
        end else if (exp_q <= 9'd1 || cnt_q == CW'(LZ_MAX)) begin
          float_d = {sign_q, 31'd0};
          uf_d    = 1'b1;
          state_d = DONE;
        end else begin
          mant_d = {mant_q[26:0], 1'b0};
          exp_d  = exp_q - 9'd1;
          cnt_d  = cnt_q + CW'(1);
        end
      end

      ROUND: begin
        if (exp_rnd >= 9'd255) begin
          float_d = {sign_q, 8'hFF, 23'd0};
          of_d    = 1'b1;
        end else begin
          float_d = {sign_q, exp_rnd[7:0], frac_rnd};
        end
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath is a handful of flops, so all of it is reset, not just the FSM.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      cnt_q     <= '0;
      special_q <= 1'b0;
      float_q   <= '0;
      of_q      <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q   <= state_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      mant_q    <= mant_d;
      cnt_q     <= cnt_d;
      special_q <= special_d;
      float_q   <= float_d;
      of_q      <= of_d;
      uf_q      <= uf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_float = float_q;
  assign of        = of_q;
  assign uf        = uf_q;

endmodule
